// File: rtl/fpu_op_sequencer_pkg.sv
// Shared definitions for the FPU op sequencer.
//   op_t        : opcodes understood by the mor1kx FPU core
//   rmode_t     : rounding modes forwarded to the core
//   err_t       : response error code
//   seq_state_t : sequencer FSM states
//   seq_req_t   : one buffered request {op, rmode, opa, opb, tag} at the
//                 default 32-bit operand / 4-bit tag widths
//   op_is_legal : true for the four opcodes the core executes
package fpu_op_sequencer_pkg;

  localparam int SEQ_WIDTH = 32;
  localparam int SEQ_TAG_W = 4;

  typedef enum logic [7:0] {
    OP_ADD = 8'h80,
    OP_SUB = 8'h81,
    OP_MUL = 8'h82,
    OP_DIV = 8'h83
  } op_t;

  typedef enum logic [1:0] {
    RM_NEAREST   = 2'd0,
    RM_ZERO      = 2'd1,
    RM_PLUS_INF  = 2'd2,
    RM_MINUS_INF = 2'd3
  } rmode_t;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_ILLOP = 2'd1,
    ERR_TMO   = 2'd2
  } err_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_t;

  // The op field is kept as raw bits: illegal opcodes must be buffered
  // too, so they can be answered with an error in order.
  typedef struct packed {
    logic [7:0]           op;
    logic [1:0]           rmode;
    logic [SEQ_WIDTH-1:0] opa;
    logic [SEQ_WIDTH-1:0] opb;
    logic [SEQ_TAG_W-1:0] tag;
  } seq_req_t;

  function automatic logic op_is_legal(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/fpu_seq_fifo.sv
// Synchronous request FIFO for the FPU op sequencer.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push       : write wr_data (honoured when not full, or full with pop)
//   pop        : drop the head entry (honoured when not empty)
//   wr_data    : entry to write
//   rd_data    : head entry, valid whenever empty is low
//   full/empty : occupancy flags from the wrapping pointer compare
module fpu_seq_fifo
  import fpu_op_sequencer_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = seq_req_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  item_t wr_data,
  output item_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  item_t       mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push while full is fine.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // The head is read combinationally: the sequencer pops and latches it
  // in the same cycle it first sees the FIFO non-empty.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// FPU op sequencer: buffers ADD/SUB/MUL/DIV requests, issues them one at
// a time to the FPU core and returns result/flags/tag/error.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid_i/ready_o : request handshake (ready when a slot is free)
//   req_op/rmode/opa/opb/tag_i : request payload
//   rsp_valid_o/ready_i : response handshake, payload held while valid
//   rsp_result/flags/tag/err_o : response payload
//   fpu_start_o         : one-cycle start pulse to the core
//   fpu_op/rmode/opa/opb_o : operands to the core, held until next pop
//   fpu_done_i, fpu_result_i, fpu_flags_i : core completion
module fpu_op_sequencer
  import fpu_op_sequencer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TMO_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [7:0]       req_op_i,
  input  logic [1:0]       req_rmode_i,
  input  logic [WIDTH-1:0] req_opa_i,
  input  logic [WIDTH-1:0] req_opb_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic [7:0]       rsp_flags_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [1:0]       rsp_err_o,
  output logic             fpu_start_o,
  output logic [7:0]       fpu_op_o,
  output logic [1:0]       fpu_rmode_o,
  output logic [WIDTH-1:0] fpu_opa_o,
  output logic [WIDTH-1:0] fpu_opb_o,
  input  logic             fpu_done_i,
  input  logic [WIDTH-1:0] fpu_result_i,
  input  logic [7:0]       fpu_flags_i
);

  // Same layout as seq_req_t, rebuilt at this instance's widths.
  typedef struct packed {
    logic [7:0]       op;
    logic [1:0]       rmode;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [TAG_W-1:0] tag;
  } req_t;

  localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  seq_state_t       state_reg, state_next;
  logic             run_reg;
  logic [7:0]       op_reg;
  logic [1:0]       rmode_reg;
  logic [WIDTH-1:0] opa_reg, opb_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [WIDTH-1:0] result_reg;
  logic [7:0]       flags_reg;
  err_t             err_reg;
  logic [CW-1:0]    tmo_cnt_reg, tmo_cnt_next;
  logic             tmo_hit;

  req_t wr_item, head;
  logic fifo_full, fifo_empty, push, pop;

  assign wr_item = '{op: req_op_i, rmode: req_rmode_i, opa: req_opa_i,
                     opb: req_opb_i, tag: req_tag_i};

  assign pop = (state_reg == ST_IDLE) && !fifo_empty;
  // run_reg keeps ready low through reset and for the release cycle's
  // edge; the pop term lets a push land in a full FIFO as the head leaves.
  assign req_ready_o = run_reg & (~fifo_full | pop);
  assign push        = req_valid_i & req_ready_o;

  fpu_seq_fifo #(
    .DEPTH  (DEPTH),
    .item_t (req_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_item),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The timeout fires on the WAIT cycle whose incremented count reaches
  // TMO_CYC-1, so the error response appears TMO_CYC cycles after start.
  assign tmo_cnt_next = tmo_cnt_reg + CNT_ONE;
  assign tmo_hit      = (tmo_cnt_next == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) state_next = op_is_legal(head.op) ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (fpu_done_i || tmo_hit) state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg     <= 1'b0;
      op_reg      <= '0;
      rmode_reg   <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      tag_reg     <= '0;
      result_reg  <= '0;
      flags_reg   <= '0;
      err_reg     <= ERR_OK;
      tmo_cnt_reg <= '0;
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            op_reg     <= head.op;
            rmode_reg  <= head.rmode;
            opa_reg    <= head.opa;
            opb_reg    <= head.opb;
            tag_reg    <= head.tag;
            result_reg <= '0;
            flags_reg  <= '0;
            err_reg    <= op_is_legal(head.op) ? ERR_OK : ERR_ILLOP;
          end
        end
        ST_ISSUE: tmo_cnt_reg <= '0;
        ST_WAIT: begin
          // done beats a coincident timeout
          if (fpu_done_i) begin
            result_reg <= fpu_result_i;
            flags_reg  <= fpu_flags_i;
            err_reg    <= ERR_OK;
          end else begin
            tmo_cnt_reg <= tmo_cnt_next;
            if (tmo_hit) begin
              result_reg <= '0;
              flags_reg  <= '0;
              err_reg    <= ERR_TMO;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fpu_start_o  = (state_reg == ST_ISSUE);
  assign rsp_valid_o  = (state_reg == ST_RESP);
  assign fpu_op_o     = op_reg;
  assign fpu_rmode_o  = rmode_reg;
  assign fpu_opa_o    = opa_reg;
  assign fpu_opb_o    = opb_reg;
  assign rsp_result_o = result_reg;
  assign rsp_flags_o  = flags_reg;
  assign rsp_tag_o    = tag_reg;
  assign rsp_err_o    = err_reg;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: directed scenarios plus a randomized burst,
// checked against a queue-based model of ordered requests and of the
// results the stub FPU hands back.
module tb_fpu_op_sequencer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int TMO   = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid_i, req_ready_o;
  logic [7:0]       req_op_i;
  logic [1:0]       req_rmode_i;
  logic [WIDTH-1:0] req_opa_i, req_opb_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             rsp_valid_o, rsp_ready_i;
  logic [WIDTH-1:0] rsp_result_o;
  logic [7:0]       rsp_flags_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic [1:0]       rsp_err_o;
  logic             fpu_start_o;
  logic [7:0]       fpu_op_o;
  logic [1:0]       fpu_rmode_o;
  logic [WIDTH-1:0] fpu_opa_o, fpu_opb_o;
  logic             fpu_done_i;
  logic [WIDTH-1:0] fpu_result_i;
  logic [7:0]       fpu_flags_i;

  fpu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_rmode_i(req_rmode_i), .req_opa_i(req_opa_i), .req_opb_i(req_opb_i),
    .req_tag_i(req_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_flags_o(rsp_flags_o), .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o),
    .fpu_start_o(fpu_start_o), .fpu_op_o(fpu_op_o), .fpu_rmode_o(fpu_rmode_o),
    .fpu_opa_o(fpu_opa_o), .fpu_opb_o(fpu_opb_o),
    .fpu_done_i(fpu_done_i), .fpu_result_i(fpu_result_i), .fpu_flags_i(fpu_flags_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [1:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } mreq_t;

  typedef struct {
    logic [31:0] res;
    logic [7:0]  fl;
    bit          tmo;
  } mout_t;

  mreq_t req_q[$];     // every accepted request, in order
  mreq_t legal_q[$];   // accepted requests the FPU should see
  mout_t issued_q[$];  // what the stub FPU returned for each start

  int vectors = 0;
  int miscompares = 0;

  // stub controls: 0 random delay 1..6, -1 never done, >0 fixed delay
  int          stub_delay = 0;
  bit          stub_res_set = 0;
  logic [31:0] stub_res_val = '0;
  int          start_count = 0;
  int          rdy_mode = 1;  // 0 hold low, 1 hold high, 2 random

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [7:0] op);
    return (op >= 8'h80) && (op <= 8'h83);
  endfunction

  task automatic chk_outs_zero(input string name);
    chk({name, "_opab"}, {fpu_opa_o, fpu_opb_o}, 64'd0);
    chk({name, "_ctl"}, {32'd0, fpu_op_o, fpu_rmode_o, fpu_start_o, req_ready_o,
                         rsp_valid_o, rsp_err_o, rsp_tag_o, rsp_flags_o}, 64'd0);
    chk({name, "_res"}, {32'd0, rsp_result_o}, 64'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] op, input logic [1:0] rm,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n;
    mreq_t m;
    n = 0;
    req_valid_i = 1'b1; req_op_i = op; req_rmode_i = rm;
    req_opa_i = a; req_opb_i = b; req_tag_i = tag;
    while (!req_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("push_bound", 64'(n < 300), 64'd1);
    end else begin
      m.op = op; m.rm = rm; m.a = a; m.b = b; m.tag = tag;
      req_q.push_back(m);
      if (legal(op)) legal_q.push_back(m);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!fpu_start_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("start_bound", 64'(n < 300), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (req_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_bound", 64'(n < 5000), 64'd1);
    @(negedge clk);
  endtask

  // Stub FPU: checks the operands at each start and answers after a delay.
  initial begin : stub_fpu
    int          cnt;
    int          d;
    logic [31:0] pend_res;
    logic [7:0]  pend_fl;
    mreq_t       m;
    mout_t       o;
    cnt = 0; pend_res = '0; pend_fl = '0;
    fpu_done_i = 1'b0; fpu_result_i = '0; fpu_flags_i = '0;
    forever begin
      @(negedge clk);
      fpu_done_i = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          fpu_done_i = 1'b1; fpu_result_i = pend_res; fpu_flags_i = pend_fl;
        end
      end
      if (fpu_start_o) begin
        start_count++;
        if (legal_q.size() == 0) begin
          chk("start_unexpected", 64'(fpu_start_o), 64'd0);
        end else begin
          m = legal_q.pop_front();
          chk("fpu_op", 64'(fpu_op_o), 64'(m.op));
          chk("fpu_rmode", 64'(fpu_rmode_o), 64'(m.rm));
          chk("fpu_opab", {fpu_opa_o, fpu_opb_o}, {m.a, m.b});
        end
        d = (stub_delay == 0) ? int'($urandom_range(1, 6)) : stub_delay;
        pend_res = stub_res_set ? stub_res_val : $urandom;
        pend_fl  = 8'($urandom_range(0, 255));
        o.res = pend_res; o.fl = pend_fl; o.tmo = (d < 0) || (d > TMO - 1);
        issued_q.push_back(o);
        cnt = (d < 0) ? 0 : d;
      end
    end
  end

  // Response consumer: drives rsp_ready_i and scores each handshake.
  initial begin : rsp_mon
    mreq_t       m;
    mout_t       o;
    logic [31:0] e_res;
    logic [7:0]  e_fl;
    logic [1:0]  e_err;
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      if (rsp_valid_o && rsp_ready_i) begin
        if (req_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
        end else begin
          m = req_q.pop_front();
          e_res = '0; e_fl = '0; e_err = 2'd1;
          if (legal(m.op)) begin
            if (issued_q.size() == 0) begin
              chk("rsp_not_issued", 64'(issued_q.size()), 64'd1);
            end else begin
              o = issued_q.pop_front();
              if (o.tmo) begin
                e_err = 2'd2;
              end else begin
                e_res = o.res; e_fl = o.fl; e_err = 2'd0;
              end
            end
          end
          chk("rsp_tag", 64'(rsp_tag_o), 64'(m.tag));
          chk("rsp_result", 64'(rsp_result_o), 64'(e_res));
          chk("rsp_flags", 64'(rsp_flags_o), 64'(e_fl));
          chk("rsp_err", 64'(rsp_err_o), 64'(e_err));
          $display("rsp tag=%0d op=%02h err=%0d result=%08h flags=%02h",
                   rsp_tag_o, m.op, rsp_err_o, rsp_result_o, rsp_flags_o);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, s0, bad;
    logic [7:0] op;
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_op_i = '0; req_rmode_i = '0;
    req_opa_i = '0; req_opb_i = '0; req_tag_i = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    chk("ready_at_release", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready_o), 64'd1);

    // 1: ADD 1.0 + 2.0, done after 3 cycles with 3.0
    stub_delay = 3; stub_res_set = 1'b1; stub_res_val = 32'h4040_0000;
    push(8'h80, 2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd5);
    wait_start(n);
    chk("lat_push_start", 64'(n), 64'd1);
    n = 0;
    while (!rsp_valid_o && n < 300) begin @(negedge clk); n++; end
    chk("lat_start_rsp", 64'(n), 64'd4);
    wait_idle();
    stub_res_set = 1'b0;

    // 2 + 5: fill the FIFO behind a slow op, then push into a full FIFO
    rdy_mode = 0;
    stub_delay = 40;
    push(8'h82, 2'd1, $urandom, $urandom, 4'd15);
    wait_start(n);
    @(negedge clk);
    stub_delay = 0;
    for (int i = 0; i < 4; i++) push(8'h80 + 8'(i), 2'(i), $urandom, $urandom, 4'(i));
    chk("full_ready_low", 64'(req_ready_o), 64'd0);
    fork
      push(8'h81, 2'd2, $urandom, $urandom, 4'd4);
      begin repeat (3) @(negedge clk); rdy_mode = 1; end
    join
    chk("pushpop_full_ready", 64'(req_ready_o), 64'd0);
    wait_idle();

    // 3: illegal op gets err 1 without a start; next op issues
    s0 = start_count;
    push(8'h84, 2'd0, $urandom, $urandom, 4'd9);
    push(8'h81, 2'd3, $urandom, $urandom, 4'd10);
    wait_idle();
    chk("illop_starts", 64'(start_count - s0), 64'd1);

    // 4: timeout exactly TMO cycles after start; done on the last cycle wins
    stub_delay = -1;
    push(8'h83, 2'd0, $urandom, $urandom, 4'd11);
    wait_start(n);
    n = 0;
    while (!rsp_valid_o && n < 300) begin @(negedge clk); n++; end
    chk("tmo_latency", 64'(n), 64'(TMO));
    wait_idle();
    stub_delay = TMO - 1;
    push(8'h80, 2'd0, $urandom, $urandom, 4'd12);
    wait_start(n);
    n = 0;
    while (!rsp_valid_o && n < 300) begin @(negedge clk); n++; end
    chk("tmo_edge_latency", 64'(n), 64'(TMO));
    wait_idle();

    // 6: reset during WAIT, late done ignored, then a clean ADD
    stub_delay = 10;
    push(8'h80, 2'd0, $urandom, $urandom, 4'd3);
    wait_start(n);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("async_rst");
    req_q.delete(); legal_q.delete(); issued_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stub_delay = 0;
    bad = 0;
    repeat (15) begin @(negedge clk); if (rsp_valid_o) bad++; end
    chk("post_rst_no_rsp", 64'(bad), 64'd0);
    stub_res_set = 1'b1; stub_res_val = 32'h4040_0000;
    push(8'h80, 2'd0, 32'h3F80_0000, 32'h4000_0000, 4'd6);
    wait_idle();
    stub_res_set = 1'b0;

    // randomized burst with random consumer backpressure
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 8'($urandom_range(0, 255));
        if (legal(op)) op = op + 8'd4;
      end else begin
        op = 8'h80 + 8'($urandom_range(0, 3));
      end
      push(op, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    rdy_mode = 1;
    chk("final_queues", 64'(legal_q.size() + issued_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
